// File: rtl/lamp_fpu_log_round_if.sv
// Handshake/data bundle between the bfloat16 log unit, its rounding stage and the downstream consumer.
interface lamp_fpu_log_round_if #(
  parameter int LAMP_FLOAT_E_DW = 8,
  parameter int LAMP_FLOAT_F_DW = 7
);
  logic                                     valid_i;
  logic                                     s_i;
  logic [LAMP_FLOAT_E_DW-1:0]               e_i;
  logic [LAMP_FLOAT_F_DW+4:0]               f_i;
  logic                                     isToRound_i;
  logic                                     isOverflow_i;
  logic                                     isUnderflow_i;
  logic                                     ready_i;
  logic                                     valid_o;
  logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW:0] result_o;
  logic                                     inexact_o;
  logic                                     ovf_o;
  logic                                     unf_o;
  logic                                     drop_o;

  modport slave (
    input  valid_i, s_i, e_i, f_i, isToRound_i, isOverflow_i, isUnderflow_i, ready_i,
    output valid_o, result_o, inexact_o, ovf_o, unf_o, drop_o
  );

  modport master (
    output valid_i, s_i, e_i, f_i, isToRound_i, isOverflow_i, isUnderflow_i, ready_i,
    input  valid_o, result_o, inexact_o, ovf_o, unf_o, drop_o
  );
endinterface

// File: rtl/lamp_fpu_log_round.sv
// Round-to-nearest-even and pack stage for the bfloat16 log unit, with a small output FIFO.
module lamp_fpu_log_round #(
  parameter int LAMP_FLOAT_E_DW = 8,
  parameter int LAMP_FLOAT_F_DW = 7,
  parameter int FIFO_DEPTH      = 2
) (
  input logic                 clk,
  input logic                 rst,
  lamp_fpu_log_round_if.slave io
);

  localparam int EW      = LAMP_FLOAT_E_DW;
  localparam int FW      = LAMP_FLOAT_F_DW;
  localparam int RW      = 1 + EW + FW;
  localparam int ENTRY_W = RW + 3;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;

  logic          lsb, guard, restSticky, roundUp;
  logic [FW+1:0] mant;
  logic [EW:0]   expSum;
  logic          expSat;

  logic          nSign;
  logic [EW-1:0] nExp;
  logic [FW-1:0] nFrac;
  logic          nInexact, nOvf, nUnf;

  logic          rValid;
  logic          rSign;
  logic [EW-1:0] rExp;
  logic [FW-1:0] rFrac;
  logic          rInexact, rOvf, rUnf;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr, rdPtr;
  logic [CNT_W-1:0]   count;
  logic               drop;
  logic               push, pop, full, doPush;
  logic [ENTRY_W-1:0] head;

  assign lsb        = io.f_i[3];
  assign guard      = io.f_i[2];
  assign restSticky = io.f_i[1] | io.f_i[0];
  assign roundUp    = io.isToRound_i & guard & (restSticky | lsb);
  assign mant       = io.f_i[FW+4:3] + (FW+2)'(roundUp);
  assign expSum     = {1'b0, io.e_i} + (EW+1)'(mant[FW+1]);
  assign expSat     = expSum[EW] | (&expSum[EW-1:0]);

  always_comb begin
    nSign    = io.s_i;
    nExp     = io.e_i;
    nFrac    = io.f_i[FW+2:3];
    nInexact = 1'b0;
    nOvf     = 1'b0;
    nUnf     = 1'b0;
    if (io.isToRound_i) begin
      nExp  = expSum[EW-1:0];
      nFrac = mant[FW+1] ? mant[FW:1] : mant[FW-1:0];
      if (io.isOverflow_i || expSat) begin
        nExp  = '1;
        nFrac = '0;
        nOvf  = 1'b1;
      end else if (io.isUnderflow_i) begin
        nExp  = '0;
        nFrac = '0;
        nUnf  = 1'b1;
      end
      nInexact = guard | restSticky | nOvf | nUnf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rValid   <= 1'b0;
      rSign    <= 1'b0;
      rExp     <= '0;
      rFrac    <= '0;
      rInexact <= 1'b0;
      rOvf     <= 1'b0;
      rUnf     <= 1'b0;
    end else begin
      rValid <= io.valid_i;
      if (io.valid_i) begin
        rSign    <= nSign;
        rExp     <= nExp;
        rFrac    <= nFrac;
        rInexact <= nInexact;
        rOvf     <= nOvf;
        rUnf     <= nUnf;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is only lost without one.
  assign push   = rValid;
  assign pop    = (count != '0) & io.ready_i;
  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign doPush = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      drop  <= 1'b0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= {rSign, rExp, rFrac, rInexact, rOvf, rUnf};
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (push && full && !pop) begin
        drop <= 1'b1;
      end
      if (doPush && !pop) begin
        count <= count + 1'b1;
      end else if (!doPush && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head         = mem[rdPtr];
  assign io.valid_o   = (count != '0);
  assign io.result_o  = head[ENTRY_W-1:3];
  assign io.inexact_o = head[2];
  assign io.ovf_o     = head[1];
  assign io.unf_o     = head[0];
  assign io.drop_o    = drop;

endmodule
